// File: rtl/mac_acc_pipe.sv
// rtl/mac_acc_pipe.sv - pipelined signed 16x16 multiply-accumulate dot-product stage (optional saturation: MAC_ACC_SAT_EN)

// 16x16 two's-complement multiplier, full 32-bit product
module mul_tc_16_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] product
);
  assign product = $signed(a) * $signed(b);
endmodule

module mac_acc_pipe #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  logic             stall;
  logic             accept;
  logic             s1_valid, s1_last;
  logic [15:0]      s1_a, s1_b;
  logic [31:0]      mul_prod;
  logic             s2_valid, s2_last;
  logic [31:0]      s2_prod;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             start;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;
  logic             s3_fire;

  // A result held against a busy consumer freezes every stage
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall && !clr;
  assign accept   = in_valid && in_ready;
  assign s3_fire  = s2_valid && !stall;

  mul_tc_16_16 u_mul (
    .a       (s1_a),
    .b       (s1_b),
    .product (mul_prod)
  );

  // S1: operand registers in front of the multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_last <= in_last;
      end
    end
  end

  // S2: product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
    end else if (clr) begin
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_prod  <= mul_prod;
      s2_last  <= s1_last;
    end
  end

  assign prod_ext = ACC_W'($signed(s2_prod));
  assign base     = start ? '0 : acc;
  assign cnt_base = start ? '0 : cnt;
  // Element count sticks at all-ones rather than wrapping
  assign cnt_next = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);

`ifdef MAC_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [ACC_W:0] sum_wide;
  logic           sat_now;
  logic           ovf;
  logic           ovf_next;

  // Saturating add: one guard bit exposes signed overflow
  always_comb begin
    sum_wide = {base[ACC_W-1], base} + {prod_ext[ACC_W-1], prod_ext};
    sat_now  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    sum      = sum_wide[ACC_W-1:0];
    if (sat_now) sum = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    ovf_next = (start ? 1'b0 : ovf) | sat_now;
  end

  // Sticky per-vector overflow, reported with the last result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf     <= 1'b0;
      out_ovf <= 1'b0;
    end else if (clr) begin
      ovf     <= 1'b0;
    end else if (s3_fire) begin
      if (s2_last) begin
        out_ovf <= ovf_next;
        ovf     <= 1'b0;
      end else begin
        ovf     <= ovf_next;
      end
    end
  end
`else
  assign sum     = base + prod_ext;
  assign out_ovf = 1'b0;
`endif

  // S3: accumulate, publish on last, and run the output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      start     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (clr) begin
      acc       <= '0;
      cnt       <= '0;
      start     <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (s3_fire) begin
        if (s2_last) begin
          out_data  <= sum;
          out_count <= cnt_next;
          out_valid <= 1'b1;
          start     <= 1'b1;
        end else begin
          acc   <= sum;
          cnt   <= cnt_next;
          start <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_pipe.sv
// tb/tb_mac_acc_pipe.sv - directed-vector bench for mac_acc_pipe (ACC_W 40 and 32 instances)

module tb_mac_acc_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_a, in_b;
  logic        in_last;
  logic        out_ready;
  logic        in_ready, out_valid, out_ovf;
  logic [39:0] out_data;
  logic [15:0] out_count;
  logic        in_ready_32, out_valid_32, out_ovf_32;
  logic [31:0] out_data_32;
  logic [15:0] out_count_32;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mac_acc_pipe #(.ACC_W(40), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf)
  );

  mac_acc_pipe #(.ACC_W(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_32),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid_32), .out_ready(out_ready),
    .out_data(out_data_32), .out_count(out_count_32), .out_ovf(out_ovf_32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int a, input int b, input logic l);
    in_valid = v;
    in_a     = 16'(a);
    in_b     = 16'(b);
    in_last  = l;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; out_ready = 1'b1;
    drive(1'b0, 0, 0, 1'b0);
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    #3 rst_n = 1'b1;
    tick();

    // 1: single pair, most negative squared, latency 2
    drive(1'b1, -32768, -32768, 1'b1);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    check("t1_lat_k",   64'(out_valid), 64'd0);
    tick();
    check("t1_lat_k1",  64'(out_valid), 64'd0);
    tick();
    check("t1_lat_k2",  64'(out_valid), 64'd1);
    check("t1_data",    64'(out_data),  64'h0040000000);
    check("t1_count",   64'(out_count), 64'd1);
    tick();
    check("t1_drain",   64'(out_valid), 64'd0);

    // 2: four-element vector then a one-element vector, no bubble
    drive(1'b1, 3, 4, 1'b0);      tick();
    drive(1'b1, -5, 6, 1'b0);     tick();
    drive(1'b1, 7, -8, 1'b0);     tick();
    drive(1'b1, 100, 100, 1'b1);  tick();
    drive(1'b1, 2, 3, 1'b1);      tick();
    drive(1'b0, 0, 0, 1'b0);
    tick();
    check("t2_v0_valid", 64'(out_valid), 64'd1);
    check("t2_v0_data",  64'(out_data),  64'd9926);
    check("t2_v0_count", 64'(out_count), 64'd4);
    tick();
    check("t2_v1_valid", 64'(out_valid), 64'd1);
    check("t2_v1_data",  64'(out_data),  64'd6);
    check("t2_v1_count", 64'(out_count), 64'd1);
    tick();
    check("t2_drain",    64'(out_valid), 64'd0);

    // 3: backpressure holds the result and blocks input
    out_ready = 1'b0;
    drive(1'b1, 2, 3, 1'b1); tick();
    drive(1'b0, 0, 0, 1'b0); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_in_ready", 64'(in_ready),  64'd0);
      check("t3_valid",    64'(out_valid), 64'd1);
      check("t3_data",     64'(out_data),  64'd6);
      check("t3_count",    64'(out_count), 64'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t3_release_valid", 64'(out_valid), 64'd0);
    check("t3_release_ready", 64'(in_ready),  64'd1);

    // 4: 3 * 2^30 at ACC_W=32 overflows the signed range
    drive(1'b1, -32768, -32768, 1'b0); tick();
    drive(1'b1, -32768, -32768, 1'b0); tick();
    drive(1'b1, -32768, -32768, 1'b1); tick();
    drive(1'b0, 0, 0, 1'b0); tick(); tick();
    check("t4_w40_valid", 64'(out_valid),    64'd1);
    check("t4_w40_data",  64'(out_data),     64'h00C0000000);
    check("t4_w40_ovf",   64'(out_ovf),      64'd0);
    check("t4_w32_valid", 64'(out_valid_32), 64'd1);
    check("t4_w32_count", 64'(out_count_32), 64'd3);
`ifdef MAC_ACC_SAT_EN
    check("t4_w32_data",  64'(out_data_32),  64'h7FFFFFFF);
    check("t4_w32_ovf",   64'(out_ovf_32),   64'd1);
`else
    check("t4_w32_data",  64'(out_data_32),  64'hC0000000);
    check("t4_w32_ovf",   64'(out_ovf_32),   64'd0);
`endif
    tick();

    // 5: clr flushes a partial vector and refuses the pair it coincides with
    drive(1'b1, 10, 10, 1'b0); tick();
    drive(1'b1, 20, 20, 1'b0); tick();
    drive(1'b1, 30, 30, 1'b1); clr = 1'b1;
    #1 check("t5_ready_in_clr", 64'(in_ready), 64'd0);
    tick();
    clr = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    tick(); tick();
    check("t5_no_result", 64'(out_valid), 64'd0);
    drive(1'b1, 2, 3, 1'b1); tick();
    drive(1'b0, 0, 0, 1'b0); tick(); tick();
    check("t5_valid", 64'(out_valid), 64'd1);
    check("t5_data",  64'(out_data),  64'd6);
    check("t5_count", 64'(out_count), 64'd1);
    tick();

    // 6: asynchronous reset mid-vector while a result is pending
    out_ready = 1'b0;
    drive(1'b1, 5, 5, 1'b1); tick();
    drive(1'b1, 7, 7, 1'b0); tick();
    drive(1'b1, 8, 8, 1'b0); tick();
    drive(1'b0, 0, 0, 1'b0);
    check("t6_pending", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_data",  64'(out_data),  64'd0);
    check("t6_rst_count", 64'(out_count), 64'd0);
    check("t6_rst_ovf",   64'(out_ovf),   64'd0);
    check("t6_rst_ready", 64'(in_ready),  64'd1);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    drive(1'b1, 1, -1, 1'b1); tick();
    drive(1'b0, 0, 0, 1'b0); tick(); tick();
    check("t6_valid", 64'(out_valid), 64'd1);
    check("t6_data",  64'(out_data),  64'hFFFFFFFFFF);
    check("t6_count", 64'(out_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
